// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered binary-to-one-hot decoder with prescaled scan mode
// Define ACTIVE_LOW_OUT_EN to drive d inverted (reset/disabled value all ones).
module scan_decoder #(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter int TICK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               hold,
  output logic [NUM_OUT-1:0] d,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap
);

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

  typedef enum logic {ST_DIRECT, ST_SCAN} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [NUM_OUT-1:0]   oh_q, oh_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    oh_d    = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!mode) begin
      state_d = ST_DIRECT;
      idx_d   = sel;
      if (en && (sel <= LAST_IDX)) begin
        oh_d    = NUM_OUT'(1) << sel;
        valid_d = 1'b1;
      end
    end else begin
      state_d = ST_SCAN;
      // Entering scan always restarts at channel 0; the step is skipped that cycle.
      if (state_q == ST_DIRECT) begin
        idx_d = '0;
        pre_d = '0;
      end else if (en && !hold) begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      if (en) begin
        oh_d    = NUM_OUT'(1) << idx_d;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DIRECT;
      pre_q   <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef ACTIVE_LOW_OUT_EN
  assign d = ~oh_q;
`else
  assign d = oh_q;
`endif
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - self-checking bench for scan_decoder (8x4 and 6x1 instances)
module tb_scan_decoder;

`ifdef ACTIVE_LOW_OUT_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic clk, rst, en, mode, hold;
  logic [2:0] sel;
  logic [7:0] d1;
  logic [5:0] d2;
  logic [2:0] idx1, idx2;
  logic valid1, valid2, wrap1, wrap2;

  int total = 0;
  int bad   = 0;

  scan_decoder #(.SEL_W(3), .NUM_OUT(8), .TICK_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .hold(hold),
    .d(d1), .idx(idx1), .valid(valid1), .wrap(wrap1));

  scan_decoder #(.SEL_W(3), .NUM_OUT(6), .TICK_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .hold(hold),
    .d(d2), .idx(idx2), .valid(valid2), .wrap(wrap2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: scan position is a single phase counter over NUM_OUT*TICK_DIV.
  int         p_n[2] = '{8, 6};
  int         p_t[2] = '{4, 1};
  bit         m_scan[2];
  int         m_pos[2];
  logic [7:0] m_d[2];
  logic [2:0] m_idx[2];
  logic       m_valid[2];
  logic       m_wrap[2];

  function automatic logic [7:0] pd8(input logic [7:0] x);
    return AL ? ~x : x;
  endfunction

  function automatic logic [5:0] pd6(input logic [5:0] x);
    return AL ? ~x : x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_scan[k] = 0; m_pos[k] = 0; m_d[k] = '0;
      m_idx[k] = '0; m_valid[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_clk();
    logic [7:0] one;
    one = 8'h01;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_scan[k] = 0; m_pos[k] = 0; m_d[k] = '0;
        m_idx[k] = '0; m_valid[k] = 0; m_wrap[k] = 0;
      end else if (!mode) begin
        m_scan[k]  = 0;
        m_idx[k]   = sel;
        m_wrap[k]  = 0;
        m_valid[k] = en && (int'(sel) < p_n[k]);
        m_d[k]     = m_valid[k] ? (one << sel) : 8'h00;
      end else begin
        if (!m_scan[k]) begin
          m_scan[k] = 1; m_pos[k] = 0; m_wrap[k] = 0;
        end else if (en && !hold) begin
          m_wrap[k] = (m_pos[k] == p_n[k] * p_t[k] - 1);
          m_pos[k]  = (m_pos[k] + 1) % (p_n[k] * p_t[k]);
        end else begin
          m_wrap[k] = 0;
        end
        m_idx[k]   = 3'(m_pos[k] / p_t[k]);
        m_valid[k] = en;
        m_d[k]     = en ? (one << m_idx[k]) : 8'h00;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; hold = 1'b0; sel = '0;
    model_reset();
    #12;
    total++;
    if ({d1, idx1, valid1, wrap1} !== {pd8(8'h00), 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_dut1 got d=%h idx=%0d v=%b w=%b exp d=%h idx=0 v=0 w=0",
               d1, idx1, valid1, wrap1, pd8(8'h00));
    end
    total++;
    if ({d2, idx2, valid2, wrap2} !== {pd6(6'h00), 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_dut2 got d=%h idx=%0d v=%b w=%b exp d=%h idx=0 v=0 w=0",
               d2, idx2, valid2, wrap2, pd6(6'h00));
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 1'b0; en = 1'b1; hold = 1'b0;
    tick();
    mode = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if ({d1, idx1, valid1, wrap1} !== {pd8(8'h00), 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got d=%h idx=%0d v=%b w=%b exp d=%h idx=0 v=0 w=0",
               d1, idx1, valid1, wrap1, pd8(8'h00));
    end
    rst = 1'b0;
    tick();
    total++;
    if ({d1, idx1, valid1} !== {pd8(8'h01), 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL post_reset_scan got d=%h idx=%0d v=%b exp d=%h idx=0 v=1",
               d1, idx1, valid1, pd8(8'h01));
    end
  endtask

  task automatic test_direct();
    logic [7:0] one, exp8;
    one = 8'h01;
    mode = 1'b0; en = 1'b1; hold = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      exp8 = one << s;
      total++;
      if ({d1, idx1, valid1} !== {pd8(exp8), 3'(s), 1'b1}) begin
        bad++;
        $display("FAIL direct sel=%0d got d=%h idx=%0d v=%b exp d=%h idx=%0d v=1",
                 s, d1, idx1, valid1, pd8(exp8), s);
      end
    end
    en = 1'b0;
    tick();
    total++;
    if ({d1, valid1} !== {pd8(8'h00), 1'b0}) begin
      bad++;
      $display("FAIL direct_disable got d=%h v=%b exp d=%h v=0", d1, valid1, pd8(8'h00));
    end
  endtask

  task automatic test_out_of_range();
    mode = 1'b0; en = 1'b1; hold = 1'b0;
    for (int s = 5; s < 8; s++) begin
      sel = 3'(s);
      tick();
      total++;
      if ({d2, idx2, valid2} !== {pd6((s == 5) ? 6'h20 : 6'h00), 3'(s), (s == 5) ? 1'b1 : 1'b0}) begin
        bad++;
        $display("FAIL out_of_range sel=%0d got d=%h idx=%0d v=%b", s, d2, idx2, valid2);
      end
    end
  endtask

  task automatic test_scan_timing();
    int wraps;
    wraps = 0;
    mode = 1'b0; en = 1'b1; hold = 1'b0;
    tick();
    mode = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      tick();
      if (k > 0 && wrap1) wraps++;
      total++;
      if ({d1, idx1, valid1, wrap1} !== {pd8(m_d[0]), m_idx[0], m_valid[0], m_wrap[0]}) begin
        bad++;
        $display("FAIL scan_dut1 k=%0d got d=%h idx=%0d v=%b w=%b exp d=%h idx=%0d v=%b w=%b",
                 k, d1, idx1, valid1, wrap1, pd8(m_d[0]), m_idx[0], m_valid[0], m_wrap[0]);
      end
      total++;
      if ({d2, idx2, valid2, wrap2} !== {pd6(m_d[1][5:0]), m_idx[1], m_valid[1], m_wrap[1]}) begin
        bad++;
        $display("FAIL scan_dut2 k=%0d got d=%h idx=%0d v=%b w=%b exp d=%h idx=%0d v=%b w=%b",
                 k, d2, idx2, valid2, wrap2, pd6(m_d[1][5:0]), m_idx[1], m_valid[1], m_wrap[1]);
      end
    end
    total++;
    if (wraps != 2) begin
      bad++;
      $display("FAIL wrap_count got %0d exp 2", wraps);
    end
  endtask

  task automatic test_hold_enable();
    mode = 1'b0; en = 1'b1; hold = 1'b0;
    tick();
    mode = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if ({d1, idx1} !== {pd8(8'h08), 3'd3}) begin
      bad++;
      $display("FAIL hold_setup got d=%h idx=%0d exp d=%h idx=3", d1, idx1, pd8(8'h08));
    end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({d1, idx1, valid1, wrap1} !== {pd8(8'h08), 3'd3, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL hold i=%0d got d=%h idx=%0d v=%b w=%b exp d=%h idx=3 v=1 w=0",
                 i, d1, idx1, valid1, wrap1, pd8(8'h08));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({d1, valid1, wrap1} !== {pd8(8'h00), 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL disable i=%0d got d=%h v=%b w=%b exp d=%h v=0 w=0",
                 i, d1, valid1, wrap1, pd8(8'h00));
      end
    end
    en = 1'b1; hold = 1'b0;
    tick(); tick();
    total++;
    if ({d1, idx1} !== {pd8(8'h08), 3'd3}) begin
      bad++;
      $display("FAIL resume_idx3 got d=%h idx=%0d exp d=%h idx=3", d1, idx1, pd8(8'h08));
    end
    tick();
    total++;
    if ({d1, idx1} !== {pd8(8'h10), 3'd4}) begin
      bad++;
      $display("FAIL resume_idx4 got d=%h idx=%0d exp d=%h idx=4", d1, idx1, pd8(8'h10));
    end
  endtask

  task automatic test_mode_switch();
    mode = 1'b1; en = 1'b1; hold = 1'b0; sel = 3'd5;
    for (int i = 0; i < 7; i++) tick();
    mode = 1'b0;
    tick();
    total++;
    if ({d1, idx1, valid1} !== {pd8(8'h20), 3'd5, 1'b1}) begin
      bad++;
      $display("FAIL to_direct got d=%h idx=%0d v=%b exp d=%h idx=5 v=1", d1, idx1, valid1, pd8(8'h20));
    end
    mode = 1'b1;
    tick();
    total++;
    if ({d1, idx1, wrap1} !== {pd8(8'h01), 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL to_scan got d=%h idx=%0d w=%b exp d=%h idx=0 w=0", d1, idx1, wrap1, pd8(8'h01));
    end
  endtask

  task automatic test_random();
    mode = 1'b1;
    for (int k = 0; k < 600; k++) begin
      en   = ($urandom % 8) != 0;
      hold = ($urandom % 6) == 0;
      sel  = 3'($urandom);
      if (($urandom % 40) == 0) mode = ~mode;
      tick();
      total++;
      if ({d1, idx1, valid1, wrap1} !== {pd8(m_d[0]), m_idx[0], m_valid[0], m_wrap[0]}) begin
        bad++;
        $display("FAIL random_dut1 k=%0d got d=%h idx=%0d v=%b w=%b exp d=%h idx=%0d v=%b w=%b",
                 k, d1, idx1, valid1, wrap1, pd8(m_d[0]), m_idx[0], m_valid[0], m_wrap[0]);
      end
      total++;
      if ({d2, idx2, valid2, wrap2} !== {pd6(m_d[1][5:0]), m_idx[1], m_valid[1], m_wrap[1]}) begin
        bad++;
        $display("FAIL random_dut2 k=%0d got d=%h idx=%0d v=%b w=%b exp d=%h idx=%0d v=%b w=%b",
                 k, d2, idx2, valid2, wrap2, pd6(m_d[1][5:0]), m_idx[1], m_valid[1], m_wrap[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_scan_timing();
    test_hold_enable();
    test_mode_switch();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
